// File: rtl/alu_arbiter.sv
// alu_arbiter
//   Two-requester front end for a single shared, purely combinational ALU.
//   Each operation runs IDLE -> EXEC -> DONE:
//     - IDLE picks a winner and captures its opcode, operands and set-flags bit.
//     - EXEC pulses the winner's gnt and drives the ALU.
//     - DONE pulses the winner's done.
//   The block never computes anything itself. It only routes operands to the
//   ALU and registers what comes back.
//
// Build option:
//   ALU_ARB_FIXED_PRIO_EN  defined   : requester 0 wins every tie.
//                          undefined : round-robin between the requesters.
//
// Ports:
//   clk, reset               clock; asynchronous active-high reset
//   req0/req1                request from requester 0 / 1
//   op0/op1                  5-bit opcode per requester
//   a0/b0, a1/b1             32-bit operands per requester
//   sf0/sf1                  set-flags enable per requester
//   gnt0/gnt1                one-cycle grant pulse (operands captured)
//   done0/done1              one-cycle completion pulse (res valid)
//   res                      result of the last completed operation
//   nzcv                     flag register {N,Z,C,V}
//   alu_op/alu_a/alu_b       drive to the shared ALU (zero outside EXEC)
//   alu_cin                  carry into the ALU, always nzcv C
//   alu_res/alu_n/alu_z/
//   alu_c/alu_v              combinational returns from the ALU
module alu_arbiter (
   input  logic        clk,
   input  logic        reset,
   input  logic        req0,
   input  logic        req1,
   input  logic [4:0]  op0,
   input  logic [4:0]  op1,
   input  logic [31:0] a0,
   input  logic [31:0] b0,
   input  logic [31:0] a1,
   input  logic [31:0] b1,
   input  logic        sf0,
   input  logic        sf1,
   output logic        gnt0,
   output logic        gnt1,
   output logic        done0,
   output logic        done1,
   output logic [31:0] res,
   output logic [3:0]  nzcv,
   output logic [4:0]  alu_op,
   output logic [31:0] alu_a,
   output logic [31:0] alu_b,
   output logic        alu_cin,
   input  logic [31:0] alu_res,
   input  logic        alu_n,
   input  logic        alu_z,
   input  logic        alu_c,
   input  logic        alu_v
);

   typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

   state_t state;
   logic   win;    // identity of the captured requester (1 = requester 1)
   logic   lsf;    // captured set-flags enable
   logic   pick;   // requester that would win if arbitration happened now

`ifdef ALU_ARB_FIXED_PRIO_EN
   always_comb begin
      pick = ~req0;
   end
`else
   logic last;     // requester granted most recently

   always_comb begin
      pick = (req0 && req1) ? ~last : ~req0;
   end
`endif

   assign alu_cin = nzcv[1];

   // The ALU drive registers double as the operand latch. They are loaded on
   // the IDLE->EXEC edge and cleared on EXEC->DONE, so the ALU sees the
   // captured operands exactly during EXEC and zero at all other times.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state  <= IDLE;
         win    <= 1'b0;
         lsf    <= 1'b0;
         gnt0   <= 1'b0;
         gnt1   <= 1'b0;
         done0  <= 1'b0;
         done1  <= 1'b0;
         res    <= '0;
         nzcv   <= '0;
         alu_op <= '0;
         alu_a  <= '0;
         alu_b  <= '0;
`ifndef ALU_ARB_FIXED_PRIO_EN
         last   <= 1'b1;
`endif
      end else begin
         gnt0  <= 1'b0;
         gnt1  <= 1'b0;
         done0 <= 1'b0;
         done1 <= 1'b0;
         case (state)
            IDLE: begin
               if (req0 || req1) begin
                  win    <= pick;
                  lsf    <= pick ? sf1 : sf0;
                  alu_op <= pick ? op1 : op0;
                  alu_a  <= pick ? a1  : a0;
                  alu_b  <= pick ? b1  : b0;
                  gnt0   <= ~pick;
                  gnt1   <= pick;
`ifndef ALU_ARB_FIXED_PRIO_EN
                  last   <= pick;
`endif
                  state  <= EXEC;
               end
            end
            EXEC: begin
               res <= alu_res;
               if (lsf) begin
                  nzcv <= {alu_n, alu_z, alu_c, alu_v};
               end
               alu_op <= '0;
               alu_a  <= '0;
               alu_b  <= '0;
               done0  <= ~win;
               done1  <= win;
               state  <= DONE;
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
